// File: rtl/button_conditioner.sv
// button_conditioner
//
// Multi-channel pushbutton front end. Each channel synchronises a raw pin,
// debounces it and derives a clean pressed level plus single-cycle press,
// release, long-press and auto-repeat pulses. Channels share nothing.
//
// Ports:
//   clk           : single clock, rising edge
//   rst           : synchronous reset, active low
//   buttons       : raw asynchronous button pins, one per channel
//   level         : debounced pressed state (1 = pressed)
//   press         : 1-cycle pulse on debounced 0->1
//   release_pulse : 1-cycle pulse on debounced 1->0
//   long_press    : 1-cycle pulse LONG_TICKS cycles after press while held
//   repeat_pulse  : 1-cycle pulse every REPEAT_TICKS cycles after long_press
module button_conditioner #(
  parameter int unsigned N_CH         = 2,
  parameter bit          ACTIVE_LOW   = 1'b0,
  parameter int unsigned BOUNCE_TICKS = 250,
  parameter int unsigned LONG_TICKS   = 6_000_000,
  parameter int unsigned REPEAT_TICKS = 1_200_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] buttons,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int unsigned DbW   = $clog2(BOUNCE_TICKS + 1);
  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);
  localparam int unsigned RepW  = (REPEAT_TICKS == 0) ? 1 : $clog2(REPEAT_TICKS + 1);

  localparam logic [DbW-1:0]   DbLast  = DbW'(BOUNCE_TICKS - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_TICKS);
  localparam logic [RepW-1:0]  RepMax  = RepW'(REPEAT_TICKS);

  typedef enum logic [1:0] {StIdle, StHeld, StLong} hold_state_e;

  logic [N_CH-1:0] raw;
  assign raw = buttons ^ {N_CH{ACTIVE_LOW}};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
    hold_state_e      state_q, state_d;

    // Debounce: s2 must differ from level for BOUNCE_TICKS consecutive cycles.
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      if (s2_q != level_q) begin
        if (db_cnt_q == DbLast) begin
          level_d = s2_q;
          press_d = s2_q;
          rel_d   = ~s2_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // Hold FSM reacts to the edge being registered this cycle, so the press
    // cycle itself counts as hold_cnt = 1 and long_press lands at P+LONG_TICKS.
    // Release is checked first so it beats a coincident threshold.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      long_d     = 1'b0;
      rep_d      = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (press_d) begin
            state_d    = StHeld;
            hold_cnt_d = HoldW'(1);
          end
        end
        StHeld: begin
          if (rel_d) begin
            state_d    = StIdle;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else if (hold_cnt_q == HoldMax) begin
            long_d    = 1'b1;
            state_d   = StLong;
            rep_cnt_d = RepW'(1);
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        StLong: begin
          if (rel_d) begin
            state_d    = StIdle;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else if (REPEAT_TICKS != 0) begin
            if (rep_cnt_q == RepMax) begin
              rep_d     = 1'b1;
              rep_cnt_d = RepW'(1);
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d    = StIdle;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1_q       <= 1'b0;
        s2_q       <= 1'b0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        rel_q      <= 1'b0;
        long_q     <= 1'b0;
        rep_q      <= 1'b0;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        state_q    <= StIdle;
      end else begin
        s1_q       <= raw[i];
        s2_q       <= s1_q;
        level_q    <= level_d;
        press_q    <= press_d;
        rel_q      <= rel_d;
        long_q     <= long_d;
        rep_q      <= rep_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        state_q    <= state_d;
      end
    end

    assign level[i]         = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = rel_q;
    assign long_press[i]    = long_q;
    assign repeat_pulse[i]  = rep_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner. Expected pulse events are queued
// with their absolute cycle when stimulus is driven; a negedge monitor pops
// and compares every pulse the DUT produces.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] buttons, buttons2;
  logic [1:0] level, press, rel, long_p, rep;
  logic [1:0] level2, press2, rel2, long2, rep2;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int long_cnt2 = 0;
  int rep_cnt2 = 0;
  int long_cyc2 = -1;

  typedef struct {
    int         cyc;
    logic [7:0] ev;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner #(
    .N_CH(2), .ACTIVE_LOW(1'b0), .BOUNCE_TICKS(4), .LONG_TICKS(20), .REPEAT_TICKS(8)
  ) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .level(level), .press(press),
    .release_pulse(rel), .long_press(long_p), .repeat_pulse(rep)
  );

  button_conditioner #(
    .N_CH(2), .ACTIVE_LOW(1'b0), .BOUNCE_TICKS(4), .LONG_TICKS(20), .REPEAT_TICKS(0)
  ) dut2 (
    .clk(clk), .rst(rst), .buttons(buttons2), .level(level2), .press(press2),
    .release_pulse(rel2), .long_press(long2), .repeat_pulse(rep2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [7:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Event vector layout: {repeat[1:0], long[1:0], release[1:0], press[1:0]}
  always @(negedge clk) begin
    logic [7:0] ev;
    exp_t       e;
    ev = {rep, long_p, rel, press};
    if (ev != 8'h00) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {24'h0, ev}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_vec", {24'h0, ev}, {24'h0, e.ev});
      end
    end
  end

  always @(negedge clk) begin
    if (long2[0]) begin
      long_cnt2++;
      long_cyc2 = cyc;
    end
    if (rep2[0]) rep_cnt2++;
  end

  initial begin
    // Reset with both buttons held
    rst      = 1'b0;
    buttons  = 2'b11;
    buttons2 = 2'b00;
    wait_to(5);
    check("reset_outs", {22'h0, level, press, rel, long_p, rep}, 32'h0);
    rst = 1'b1;
    push(11, 8'b0000_0011);
    wait_to(10);
    check("reset_level_pre", {30'h0, level}, 32'h0);
    wait_to(11);
    check("reset_level_post", {30'h0, level}, 32'h3);
    buttons = 2'b00;
    push(17, 8'b0000_1100);
    wait_to(17);
    check("level_released", {30'h0, level}, 32'h0);

    // Bounce rejection on ch0, then release landing on the long threshold
    wait_to(20); buttons[0] = 1'b1;
    wait_to(22); buttons[0] = 1'b0;
    wait_to(24); buttons[0] = 1'b1;
    wait_to(26); buttons[0] = 1'b0;
    wait_to(28); buttons[0] = 1'b1;
    wait_to(30); buttons[0] = 1'b0;
    push(38, 8'b0000_0001);
    wait_to(32); buttons[0] = 1'b1;
    check("bounce_level", {30'h0, level}, 32'h0);
    wait_to(37);
    check("bounce_level_pre", {30'h0, level}, 32'h0);
    wait_to(38);
    check("bounce_level_post", {30'h0, level}, 32'h1);
    push(58, 8'b0000_0100);
    wait_to(52); buttons[0] = 1'b0;
    wait_to(57);
    check("thresh_level_pre", {30'h0, level}, 32'h1);
    wait_to(58);
    check("thresh_level_post", {30'h0, level}, 32'h0);

    // ch1 long hold with repeats, ch0 short press alongside; dut2 long hold
    wait_to(70);
    buttons[1]  = 1'b1;
    buttons2[0] = 1'b1;
    push(76, 8'b0000_0010);
    push(78, 8'b0000_0001);
    push(88, 8'b0000_0100);
    push(96, 8'b0010_0000);
    push(104, 8'b1000_0000);
    push(112, 8'b1000_0000);
    push(120, 8'b1000_0000);
    push(128, 8'b1000_0000);
    push(136, 8'b0000_1000);
    wait_to(72); buttons[0] = 1'b1;
    wait_to(82); buttons[0] = 1'b0;
    wait_to(96);
    check("long_level", {30'h0, level}, 32'h2);
    wait_to(130); buttons[1] = 1'b0;
    wait_to(136);
    check("long_release_level", {30'h0, level}, 32'h0);
    wait_to(180);
    check("norep_long_cnt", long_cnt2, 1);
    check("norep_long_cyc", long_cyc2, 96);
    check("norep_rep_cnt", rep_cnt2, 0);
    check("norep_level", {30'h0, level2}, 32'h1);

    // Reset in the middle of a long hold
    wait_to(190);
    buttons[1] = 1'b1;
    push(196, 8'b0000_0010);
    push(216, 8'b0010_0000);
    push(224, 8'b1000_0000);
    wait_to(226);
    check("midhold_level", {30'h0, level}, 32'h2);
    rst = 1'b0;
    wait_to(227);
    check("midhold_reset_outs", {22'h0, level, press, rel, long_p, rep}, 32'h0);
    wait_to(228);
    rst = 1'b1;
    push(234, 8'b0000_0010);
    wait_to(233);
    check("repress_level_pre", {30'h0, level}, 32'h0);
    wait_to(234);
    check("repress_level_post", {30'h0, level}, 32'h2);
    wait_to(236);
    buttons[1] = 1'b0;
    push(242, 8'b0000_1000);
    wait_to(260);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel pushbutton front end for the etch-a-sketch board and later labs. Each channel synchronises a raw button pin, debounces it, and produces a clean level plus single-cycle press, release, long-press and auto-repeat pulses. It replaces the single-channel debouncer. It sits between the board `buttons` pins and the user-facing state machines (LED/RGB sequencer, cursor control).

## Interface
- `N_CH`, 2, number of independent button channels.
- `ACTIVE_LOW`, 0, 1 = pin reads 0 when pressed; the pin is inverted before the synchroniser.
- `BOUNCE_TICKS`, 250, consecutive cycles a new synchronised value must hold before `level` accepts it; must be ≥1.
- `LONG_TICKS`, 6_000_000, cycles from the `press` cycle to the `long_press` cycle (0.5 s at 12 MHz); must be ≥1.
- `REPEAT_TICKS`, 1_200_000, auto-repeat period after `long_press`; 0 disables repeat.

Ports (reset first, then data):
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-low. `rst`=0 on a rising edge resets all state.
- `buttons` input N_CH: raw asynchronous pins.
- `level` output N_CH: debounced pressed state, 1 = pressed.
- `press` output N_CH: 1-cycle pulse on debounced 0→1.
- `release` output N_CH: 1-cycle pulse on debounced 1→0.
- `long_press` output N_CH: 1-cycle pulse when held LONG_TICKS cycles.
- `repeat_pulse` output N_CH: 1-cycle pulse every REPEAT_TICKS cycles after `long_press` while held.

## Operation
- Channels are fully independent: one generate loop instantiates identical per-channel logic, with no shared counters.
- Normalise: `raw = buttons ^ {N_CH{ACTIVE_LOW}}`.
- Synchroniser: 2 flops, `s1 <= raw; s2 <= s1`, both reset to 0 (not pressed).
- Debounce:
  - Counter `db_cnt` has width $clog2(BOUNCE_TICKS+1).
  - When `s2 == level`, `db_cnt <= 0`.
  - Otherwise, if `db_cnt == BOUNCE_TICKS-1`, then `level <= s2` and `db_cnt <= 0`; else `db_cnt` increments.
  - Any glitch back to `level` restarts the count.
- Edge pulses: `press`/`release` are registered and asserted in the same cycle in which `level` first shows the new value. They are never both high.
- Hold FSM per channel, states IDLE, HELD, LONG:
  - IDLE: on press → HELD, `hold_cnt <= 1`.
  - HELD, release → IDLE, counters cleared, no `long_press`.
  - HELD, otherwise: if `hold_cnt == LONG_TICKS`, then pulse `long_press` → LONG with `rep_cnt <= 1`; else `hold_cnt` increments.
  - LONG, release → IDLE.
  - LONG, otherwise, with REPEAT_TICKS≠0: if `rep_cnt == REPEAT_TICKS`, pulse `repeat_pulse` and `rep_cnt <= 1`; else `rep_cnt` increments.
  - Counter widths: `hold_cnt` $clog2(LONG_TICKS+1); `rep_cnt` $clog2(REPEAT_TICKS+1), minimum 1 bit.
- Simultaneous events:
  - Release in the same cycle as the long or repeat threshold: release wins and no `long_press`/`repeat_pulse` is emitted.
  - Counters saturate by construction; no wrap is possible while held.
- Reset:
  - All outputs 0, sync flops 0, counters 0, FSM IDLE, applied on the first `clk` edge with `rst`=0.
  - A button held through reset is seen as a fresh press after debounce.
  - Reset mid-hold aborts the hold silently: no `release` pulse.

## Timing
- Pin-to-`level` latency: the stable input is first sampled into `s1` on edge 0, and `level`/`press` update on edge BOUNCE_TICKS+1.
- `long_press` fires exactly LONG_TICKS cycles after the `press` cycle P, i.e. at P+LONG_TICKS.
- `repeat_pulse` fires at P+LONG_TICKS+k·REPEAT_TICKS for k≥1 while held.
- `release` timing mirrors `press`: the cycle `level` falls. The FSM is IDLE in the next cycle, so a new `press` is possible no earlier than BOUNCE_TICKS cycles later.
- All outputs are registered; no combinational path exists from `buttons` to any output.

## Test plan
Bench parameters: N_CH=2, ACTIVE_LOW=0, BOUNCE_TICKS=4, LONG_TICKS=20, REPEAT_TICKS=8.
- Reset with held buttons: hold `rst`=0 and `buttons`=2'b11 for 5 cycles, then release reset → all outputs 0 during reset. Afterwards, `level` goes to 2'b11 and `press` pulses 2'b11 for exactly 1 cycle, 5 cycles after the first sampling edge.
- Bounce rejection: toggle `buttons[0]` every 2 cycles for 12 cycles, then hold it at 1 → no `press` during the toggling; exactly one `press[0]` 5 cycles after the final transition is sampled.
- Long press and repeat: with `press[1]` at cycle P, hold for 60 cycles → `long_press[1]` at P+20; `repeat_pulse[1]` at P+28, P+36, P+44, P+52; `release[1]` when `level` falls; no pulses after that.
- Release at threshold: time the input drop so that `level[0]` falls at P+20 → `release[0]` at P+20, no `long_press[0]`, FSM IDLE.
- Channel independence and repeat disable: with ch0 doing a 10-cycle short press while ch1 does a long hold → ch0 shows only `press`/`release` and ch1's pulses are unaffected. A second instance with REPEAT_TICKS=0 gives one `long_press` and zero `repeat_pulse` over 100 held cycles.
- Reset mid-hold: assert `rst`=0 in LONG at P+30 → all outputs 0 on the next edge, no `release` pulse. After deasserting reset with the button still held, a new `press` arrives 5 cycles later.
